inst_prefetch_buf: RTL and testbench

//  Instruction prefetch queue between the openmips fetch port and a synchronous instruction ROM.

---
 rtl/inst_prefetch_buf_pkg.sv | 15 +
 rtl/inst_prefetch_buf_fifo.sv | 63 ++++++
 rtl/inst_prefetch_buf.sv | 95 +++++++++
 tb/tb_inst_prefetch_buf.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_buf_pkg.sv
// Shared widths, constants and PC arithmetic for the instruction prefetch buffer.
package inst_prefetch_buf_pkg;

    localparam int              ADDR_W     = 32;
    localparam int              INST_W     = 32;
    localparam logic [INST_W-1:0] ZERO_WORD  = '0;
    localparam logic            RST_ACTIVE = 1'b0;
    localparam logic [ADDR_W-1:0] PC_STEP    = 32'd4;

    // Sequential word address; wraps mod 2^32 with no error.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/inst_prefetch_buf_fifo.sv
// In-order instruction word queue: DEPTH x 32, push/pop/clear, pointer-only reset.
module inst_prefetch_buf_fifo
    import inst_prefetch_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    clear_i,
    input  logic [INST_W-1:0]       wdata_i,
    output logic [INST_W-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0]  cnt_o,
    output logic                    empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/inst_prefetch_buf.sv
// Sequential instruction prefetcher between the core fetch port and a synchronous ROM.
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [INST_W-1:0] cpu_inst_o,
    output logic              cpu_ack_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              rom_valid_i
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              started_q;

    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic [INST_W-1:0] head_word;
    logic [CW:0]       occupancy;
    logic              redirect, hit, issue, ret, push;

    // Occupancy counts reads already marked for drop, so a flush cannot overrun the ROM.
    assign occupancy = {1'b0, fifo_cnt} + {1'b0, outst_q};
    assign redirect  = cpu_req_i && (cpu_addr_i != exp_addr_q);
    assign hit       = cpu_req_i && !redirect && !fifo_empty;
    assign issue     = started_q && !redirect && (occupancy < DEPTH_OCC);
    assign ret       = rom_valid_i && (outst_q != '0);
    assign push      = ret && (drop_q == '0) && !redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        exp_addr_d = exp_addr_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(issue) - CW'(ret);
        if (redirect) begin
            fetch_pc_d = cpu_addr_i;
            exp_addr_d = cpu_addr_i;
            drop_d     = outst_q - CW'(ret);
        end else begin
            if (issue) fetch_pc_d = next_pc(fetch_pc_q);
            if (hit)   exp_addr_d = next_pc(exp_addr_q);
            if (ret && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    // started_q keeps the ROM strobe quiet for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            fetch_pc_q <= RESET_PC;
            exp_addr_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            exp_addr_q <= exp_addr_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            started_q  <= 1'b1;
        end
    end

    inst_prefetch_buf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (hit),
        .clear_i (redirect),
        .wdata_i (rom_data_i),
        .rdata_o (head_word),
        .cnt_o   (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign cpu_ack_o  = hit;
    assign cpu_inst_o = hit ? head_word : ZERO_WORD;
    assign rom_ce_o   = issue;
    assign rom_addr_o = issue ? fetch_pc_q : '0;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Randomised and directed bench for inst_prefetch_buf against a queue-level reference model.
`timescale 1ns/1ps
module tb_inst_prefetch_buf;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] ROM_KEY = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_inst_o;
    logic        cpu_ack_o;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = '0;
    logic        rom_valid_i = 1'b0;

    inst_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_inst_o  (cpu_inst_o),
        .cpu_ack_o   (cpu_ack_o),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .rom_valid_i (rom_valid_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ ROM_KEY;
    endfunction

    // Reference model: words waiting for the core, and reads in flight tagged stale or live.
    logic [31:0] m_pc, m_exp;
    logic [31:0] m_q[$];
    bit          m_infl[$];
    bit          m_started;

    // ROM model driven by the DUT's own strobe.
    typedef struct { logic [31:0] addr; int due; } rd_t;
    rd_t pend[$];
    int  cyc = 0;
    int  lat_lo = 2, lat_hi = 2;

    task automatic model_reset();
        m_pc = 32'h0;
        m_exp = 32'h0;
        m_q.delete();
        m_infl.delete();
        m_started = 1'b0;
        pend.delete();
    endtask

    task automatic reset_dut();
        cpu_req_i = 1'b0;
        cpu_addr_i = '0;
        rom_valid_i = 1'b0;
        rom_data_i = '0;
        rst = 1'b0;
        model_reset();
        #1;
        check("reset_rom_ce", rom_ce_o, 1'b0);
        check("reset_rom_addr", rom_addr_o, 32'h0);
        check("reset_cpu_ack", cpu_ack_o, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic step(input logic req, input logic [31:0] addr,
                        output logic ack, output logic [31:0] inst,
                        output logic ce, output logic [31:0] ce_addr);
        logic        redirect, e_ack, e_ce, rv;
        logic [31:0] e_inst, e_addr, rd;
        bit          stale;
        int          due;
        @(negedge clk);
        cpu_req_i = req;
        cpu_addr_i = addr;
        rv = (pend.size() != 0) && (pend[0].due <= cyc);
        rom_valid_i = rv;
        rom_data_i = rv ? rom_word(pend[0].addr) : 32'($urandom());
        rd = rom_data_i;
        #1;
        redirect = req && (addr != m_exp);
        e_ack    = req && !redirect && (m_q.size() != 0);
        e_inst   = e_ack ? m_q[0] : 32'h0;
        e_ce     = m_started && !redirect && ((m_q.size() + m_infl.size()) < DEPTH);
        e_addr   = e_ce ? m_pc : 32'h0;
        check("cpu_ack_o", cpu_ack_o, e_ack);
        check("cpu_inst_o", cpu_inst_o, e_inst);
        check("rom_ce_o", rom_ce_o, e_ce);
        check("rom_addr_o", rom_addr_o, e_addr);
        if (cpu_ack_o) check("ack_data_vs_rom", cpu_inst_o, rom_word(addr));
        ack = cpu_ack_o;
        inst = cpu_inst_o;
        ce = rom_ce_o;
        ce_addr = rom_addr_o;

        stale = 1'b1;
        if (rv) begin
            if (m_infl.size() != 0) stale = m_infl.pop_front();
            pend.delete(0);
        end
        if (redirect) begin
            m_q.delete();
            m_exp = addr;
            m_pc = addr;
            foreach (m_infl[i]) m_infl[i] = 1'b1;
        end else begin
            if (e_ack) begin
                m_q.delete(0);
                m_exp = m_exp + 32'd4;
            end
            if (rv && !stale) m_q.push_back(rd);
            if (e_ce) begin
                m_infl.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
        end
        if (rom_ce_o) begin
            rd_t r;
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (pend.size() != 0 && due <= pend[$].due) due = pend[$].due + 1;
            r.addr = rom_addr_o;
            r.due = due;
            pend.push_back(r);
        end
        check("rom_inflight_le_depth", 32'(pend.size() <= DEPTH), 32'd1);
        m_started = 1'b1;
        cyc++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a, ce;
        logic [31:0] d, ca, nxt, r32, addr;
        logic [31:0] wrap_addr[$];
        int          first, n_acks, n_ce, t_ack;
        bit          req;

        // 1: sequential streaming from reset
        reset_dut();
        lat_lo = 2; lat_hi = 2;
        nxt = 32'h0; first = -1; n_acks = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, nxt, a, d, ce, ca);
            if (a) begin
                if (first < 0) begin
                    first = k;
                    check("t1_first_data", d, 32'hA5A50000);
                end
                n_acks++;
                nxt = nxt + 32'd4;
            end
        end
        check("t1_first_ack_cycle", first, 4);
        check("t1_acks_no_gaps", n_acks, 16);

        // 2: idle core, queue fills then ROM strobe stops
        reset_dut();
        n_ce = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, a, d, ce, ca);
            if (ce) begin
                check("t2_ce_addr", ca, 32'(n_ce * 4));
                n_ce++;
            end
        end
        check("t2_ce_pulses", n_ce, DEPTH);

        // 3/4: redirect after two acks, with a ROM word returning in the redirect cycle
        reset_dut();
        nxt = 32'h0; a = 1'b0;
        for (int k = 0; k < 20 && nxt != 32'h8; k++) begin
            step(1'b1, nxt, a, d, ce, ca);
            if (a) nxt = nxt + 32'd4;
        end
        check("t3_reached_two_acks", nxt, 32'h8);
        step(1'b1, 32'h100, a, d, ce, ca);
        check("t3_no_ack_on_redirect", a, 1'b0);
        check("t4_return_in_redirect", rom_valid_i, 1'b1);
        step(1'b1, 32'h100, a, d, ce, ca);
        check("t3_first_issue_addr", ca, 32'h100);
        t_ack = -1;
        for (int k = 2; k < 12 && t_ack < 0; k++) begin
            step(1'b1, 32'h100, a, d, ce, ca);
            if (a) begin
                t_ack = k;
                check("t3_ack_data", d, 32'hA5A50100);
            end
        end
        check("t3_ack_latency", t_ack, 4);

        // 5: random latency, request gaps and redirects
        reset_dut();
        lat_lo = 1; lat_hi = 5;
        n_acks = 0;
        for (int k = 0; k < 3000; k++) begin
            req = ($urandom_range(0, 9) < 7);
            r32 = $urandom();
            case ($urandom_range(0, 19))
                0:       addr = {r32[31:2], 2'b00};
                1:       addr = m_exp + 32'(4 * $urandom_range(1, 3));
                default: addr = m_exp;
            endcase
            step(req, addr, a, d, ce, ca);
            if (a) n_acks++;
        end
        check("t5_enough_acks", 32'(n_acks > 300), 32'd1);

        // 6: address wrap, then asynchronous reset mid-cycle
        reset_dut();
        lat_lo = 2; lat_hi = 2;
        step(1'b0, 32'h0, a, d, ce, ca);
        nxt = 32'hFFFFFFF8;
        for (int k = 0; k < 24 && wrap_addr.size() < 4; k++) begin
            step(1'b1, nxt, a, d, ce, ca);
            if (a) begin
                wrap_addr.push_back(nxt);
                nxt = nxt + 32'd4;
            end
        end
        check("t6_wrap_ack_count", wrap_addr.size(), 4);
        if (wrap_addr.size() == 4) begin
            check("t6_wrap_ack0", wrap_addr[0], 32'hFFFFFFF8);
            check("t6_wrap_ack1", wrap_addr[1], 32'hFFFFFFFC);
            check("t6_wrap_ack2", wrap_addr[2], 32'h00000000);
            check("t6_wrap_ack3", wrap_addr[3], 32'h00000004);
        end
        step(1'b1, nxt, a, d, ce, ca);
        check("t6_pre_reset_ack", a, 1'b1);
        check("t6_pre_reset_ce", ce, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("t6_async_rst_ce", rom_ce_o, 1'b0);
        check("t6_async_rst_ack", cpu_ack_o, 1'b0);
        check("t6_async_rst_inst", cpu_inst_o, 32'h0);
        reset_dut();
        nxt = 32'h0; n_acks = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, nxt, a, d, ce, ca);
            if (a) begin
                n_acks++;
                nxt = nxt + 32'd4;
            end
        end
        check("t6_recovery_acks", n_acks, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
